multicast_mac_row: RTL and testbench

//  Pipelined, parametrised successor to the 4-lane scalar-times-row multiplier of the SpMM datapath.

---
 rtl/multicast_mac_row.sv | 134 +++++++++++++
 tb/tb_multicast_mac_row.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicast_mac_row.sv
`default_nettype none
// ============================================================================
// Module      : multicast_mac_row
// Description : Scalar-times-row multiply-accumulate for the SpMM datapath.
//               Each accepted beat multiplies scalar A(i,k) by row B(k,:)
//               across LANES lanes (stage S1), then accumulates the products
//               into row C(i,:) (stage S2). The beat flagged last emits the
//               finished row with the number of beats that built it.
// Ports       : clk_i, rst_i             clock, synchronous active-high reset
//               in_valid_i/in_ready_o    input handshake
//               scA_i, rowB_i, in_last_i input beat (lane j at [j*DW +: DW])
//               out_valid_o/out_ready_i  output handshake
//               rowC_o, nnz_o            finished row and its beat count
// Revision    : 1.0 - initial release
// ============================================================================
module multicast_mac_row #(
    parameter int LANES  = 4,
    parameter int DW     = 32,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DW-1:0]       scA_i,
    input  logic [LANES*DW-1:0] rowB_i,
    input  logic                in_last_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [LANES*DW-1:0] rowC_o,
    output logic [CNT_W-1:0]    nnz_o
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    // S1: registered products
    logic                r_s1_valid;
    logic                r_s1_last;
    logic [LANES*DW-1:0] r_prod;

    // S2: running row state and output register
    logic [LANES*DW-1:0] r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_out_valid;
    logic [LANES*DW-1:0] r_row_c;
    logic [CNT_W-1:0]    r_nnz;

    logic [LANES*DW-1:0] w_prod;
    logic [LANES*DW-1:0] w_sum;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_stall;
    logic                w_accept;
    logic                w_s2_fire;

    // Only a finishing beat needs the output register; partial beats can
    // always fold into the accumulator, so they never stall.
    assign w_stall   = r_s1_valid & r_s1_last & r_out_valid & ~out_ready_i;
    assign in_ready_o = ~rst_i & ~w_stall;
    assign w_accept  = in_valid_i & in_ready_o;
    assign w_s2_fire = r_s1_valid & ~w_stall;

    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            logic [DW-1:0] w_b;
            assign w_b = rowB_i[j*DW +: DW];

            // A DW x DW -> DW product: the low DW bits are the same for
            // signed and unsigned operands; SIGNED only picks the operand
            // interpretation.
            if (SIGNED != 0) begin : g_signed
                logic signed [DW-1:0] w_p;
                assign w_p = $signed(scA_i) * $signed(w_b);
                assign w_prod[j*DW +: DW] = w_p;
            end else begin : g_unsigned
                assign w_prod[j*DW +: DW] = scA_i * w_b;
            end

            assign w_sum[j*DW +: DW] = r_acc[j*DW +: DW] + r_prod[j*DW +: DW];
        end
    endgenerate

    // Stage S1: multiply
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_prod     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_last  <= in_last_i;
            r_prod     <= w_prod;
        end else if (w_s2_fire) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage S2: accumulate and emit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_row_c     <= '0;
            r_nnz       <= '0;
        end else begin
            if (r_out_valid && out_ready_i) begin
                r_out_valid <= 1'b0;
            end
            if (w_s2_fire) begin
                if (r_s1_last) begin
                    // A row landing on the drain edge overrides the clear
                    // above, so back-to-back rows leave no bubble.
                    r_row_c     <= w_sum;
                    r_nnz       <= w_cnt_inc;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign rowC_o      = r_row_c;
    assign nnz_o       = r_nnz;

endmodule
`default_nettype wire

// File: tb/tb_multicast_mac_row.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicast_mac_row
// Description : Self-checking bench for multicast_mac_row. Two instances
//               (unsigned and signed operand mode) share one input stream;
//               a row-level scoreboard predicts every emitted row.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicast_mac_row;

    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int CNT_W = 8;
    localparam int RW    = LANES * DW;

    typedef struct packed {
        logic [RW-1:0]    row;
        logic [CNT_W-1:0] nnz;
    } row_t;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [DW-1:0]   sc_a;
    logic [RW-1:0]   row_b;
    logic            in_last;
    logic            ready_val;
    logic            rand_phase;
    logic            r_rand_ready;
    logic            out_ready;

    logic            in_ready0, in_ready1;
    logic            out_valid0, out_valid1;
    logic [RW-1:0]   row_c0, row_c1;
    logic [CNT_W-1:0] nnz0, nnz1;

    int checks = 0;
    int fails  = 0;

    row_t           exp_q[$];
    logic [DW-1:0]  m_acc[LANES];
    int             m_cnt;

    assign out_ready = rand_phase ? r_rand_ready : ready_val;

    multicast_mac_row #(.LANES(LANES), .DW(DW), .SIGNED(0), .CNT_W(CNT_W)) u_dut_u (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready0),
        .scA_i(sc_a), .rowB_i(row_b), .in_last_i(in_last),
        .out_valid_o(out_valid0), .out_ready_i(out_ready),
        .rowC_o(row_c0), .nnz_o(nnz0)
    );

    multicast_mac_row #(.LANES(LANES), .DW(DW), .SIGNED(1), .CNT_W(CNT_W)) u_dut_s (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .scA_i(sc_a), .rowB_i(row_b), .in_last_i(in_last),
        .out_valid_o(out_valid1), .out_ready_i(out_ready),
        .rowC_o(row_c1), .nnz_o(nnz1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        #1;
        r_rand_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Row-level reference: a row is the lane-wise sum of scalar*row products
    // over its beats; its count is the beat count clipped at 2^CNT_W-1.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
            for (int j = 0; j < LANES; j++) m_acc[j] = '0;
        end else begin
            if (out_valid0) begin
                if (exp_q.size() == 0) begin
                    chk("u_spurious_row", RW'(1), RW'(0));
                end else begin
                    chk("u_rowC", row_c0, exp_q[0].row);
                    chk("u_nnz", RW'(nnz0), RW'(exp_q[0].nnz));
                end
            end
            if (out_valid1) begin
                if (exp_q.size() == 0) begin
                    chk("s_spurious_row", RW'(1), RW'(0));
                end else begin
                    chk("s_rowC", row_c1, exp_q[0].row);
                    chk("s_nnz", RW'(nnz1), RW'(exp_q[0].nnz));
                end
            end
            // Only a held output can block input; otherwise one beat/cycle.
            if (in_valid && !(out_valid0 && !out_ready))
                chk("u_in_ready_thru", RW'(in_ready0), RW'(1));
            if (in_valid && !(out_valid1 && !out_ready))
                chk("s_in_ready_thru", RW'(in_ready1), RW'(1));

            if (in_valid && in_ready0) begin
                for (int j = 0; j < LANES; j++)
                    m_acc[j] = m_acc[j] + sc_a * row_b[j*DW +: DW];
                m_cnt = (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
                if (in_last) begin
                    row_t r;
                    for (int j = 0; j < LANES; j++) r.row[j*DW +: DW] = m_acc[j];
                    r.nnz = CNT_W'(m_cnt);
                    exp_q.push_back(r);
                    m_cnt = 0;
                    for (int j = 0; j < LANES; j++) m_acc[j] = '0;
                end
            end
            if (out_valid0 && out_ready && exp_q.size() != 0)
                void'(exp_q.pop_front());
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_beat(input logic [DW-1:0] a, input logic [RW-1:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1;
        sc_a     = a;
        row_b    = b;
        in_last  = last;
        @(negedge clk);
        while (!in_ready0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready0) chk("send_timeout", RW'(0), RW'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Returns at a negedge with out_valid high (or after the bound expires).
    task automatic wait_out();
        int n = 0;
        @(negedge clk);
        while (!out_valid0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid0) chk("wait_out_timeout", RW'(0), RW'(1));
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", RW'(exp_q.size()), RW'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b1;
        sc_a       = 32'd9;
        row_b      = {4{32'd9}};
        in_last    = 1'b1;
        ready_val  = 1'b1;
        rand_phase = 1'b0;

        // Reset with a beat offered: nothing taken, outputs cleared
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready_u", RW'(in_ready0), RW'(0));
            chk("rst_in_ready_s", RW'(in_ready1), RW'(0));
            chk("rst_out_valid", RW'(out_valid0), RW'(0));
            chk("rst_nnz", RW'(nnz0), RW'(0));
            chk("rst_rowC", row_c0, RW'(0));
        end
        @(posedge clk);
        #1;
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two-beat row, latency check
        send_beat(32'd2, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
        send_beat(32'd3, {32'd40, 32'd30, 32'd20, 32'd10}, 1'b1);
        idle();
        @(negedge clk);
        chk("lat_not_yet", RW'(out_valid0), RW'(0));
        @(negedge clk);
        chk("lat_valid", RW'(out_valid0), RW'(1));
        chk("row2_rowC", row_c0, {32'd128, 32'd96, 32'd64, 32'd32});
        chk("row2_nnz", RW'(nnz0), RW'(2));
        @(posedge clk);
        #1;
        drain();

        // Wrap-around and negative scalar
        send_beat(32'h8000_0000, {4{32'd2}}, 1'b0);
        send_beat(32'h8000_0000, {4{32'd2}}, 1'b1);
        idle();
        wait_out();
        chk("wrap_rowC", row_c0, RW'(0));
        chk("wrap_nnz", RW'(nnz0), RW'(2));
        @(posedge clk);
        #1;
        drain();
        send_beat(32'hFFFF_FFFF, {4{32'd5}}, 1'b1);
        idle();
        wait_out();
        chk("neg_rowC_u", row_c0, {4{32'hFFFF_FFFB}});
        chk("neg_rowC_s", row_c1, {4{32'hFFFF_FFFB}});
        chk("neg_nnz", RW'(nnz0), RW'(1));
        @(posedge clk);
        #1;
        drain();

        // Backpressure with two single-beat rows
        ready_val = 1'b0;
        send_beat(32'd1, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1);
        send_beat(32'd2, {4{32'd1}}, 1'b1);
        idle();
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", RW'(in_ready0), RW'(0));
            chk("bp_hold_valid", RW'(out_valid0), RW'(1));
            chk("bp_hold_rowC", row_c0, {32'd4, 32'd3, 32'd2, 32'd1});
        end
        @(posedge clk);
        #1;
        ready_val = 1'b1;
        @(negedge clk);
        chk("bp_first_rowC", row_c0, {32'd4, 32'd3, 32'd2, 32'd1});
        @(negedge clk);
        chk("bp_second_valid", RW'(out_valid0), RW'(1));
        chk("bp_second_rowC", row_c0, {4{32'd2}});
        chk("bp_second_nnz", RW'(nnz0), RW'(1));
        @(posedge clk);
        #1;
        drain();

        // Reset in the middle of a row
        send_beat(32'd5, {4{32'd3}}, 1'b0);
        send_beat(32'd6, {4{32'd3}}, 1'b0);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_beat(32'd1, {4{32'd7}}, 1'b1);
        idle();
        wait_out();
        chk("mid_rst_rowC", row_c0, {4{32'd7}});
        chk("mid_rst_nnz", RW'(nnz0), RW'(1));
        @(posedge clk);
        #1;
        drain();

        // Beat counter saturation
        for (int i = 0; i < 260; i++) send_beat(32'd1, {4{32'd1}}, (i == 259));
        idle();
        wait_out();
        chk("sat_rowC", row_c0, {4{32'd260}});
        chk("sat_nnz", RW'(nnz0), RW'(255));
        @(posedge clk);
        #1;
        drain();

        // Random rows under random backpressure
        rand_phase = 1'b1;
        for (int r = 0; r < 100; r++) begin
            int nb;
            nb = $urandom_range(1, 8);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 5) == 0) begin
                    idle();
                    @(posedge clk);
                    #1;
                end
                send_beat($urandom, {$urandom, $urandom, $urandom, $urandom}, (b == nb - 1));
            end
        end
        idle();
        rand_phase = 1'b0;
        drain();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire
